dmem_axil_bridge: RTL

DMEM_AXIL_BRIDGE -- requirements
Module: dmem_axil_bridge

---
 rtl/dmem_axil_bridge.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_axil_bridge.sv
// ----------------------------------------------------------------------------
// dmem_axil_bridge
//
// AXI4-Lite slave that fronts a 1 KB word-organised data memory with a
// registered read port. Exactly one transaction is in flight at a time.
// Simultaneous write and read requests are arbitrated round-robin.
//
// Optional feature (compile-time macro DMEM_BRIDGE_ERR_EN):
//   When defined, any address whose bits [31:10] differ from BASE_ADDR[31:10]
//   returns SLVERR (2'b10). Writes are suppressed (mem_write stays low) and
//   reads return zero data. Handshake timing is identical either way.
//   When undefined, address bits [31:10] are ignored (the window aliases)
//   and every response is OKAY.
//
// Parameters:
//   BASE_ADDR   byte base of the 1 KB window; bits [9:0] ignored
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready      write response channel
//   araddr/arvalid/arready   read address channel
//   rdata/rresp/rvalid/rready read data channel
//   mem_write                memory write strobe (one cycle per write)
//   byte_en                  byte lane enables for the memory write
//   write_addr               memory write word index
//   read_addr                memory read byte address
//   write_data               memory write data
//   read_data                memory read data, valid one cycle after read_addr
// ----------------------------------------------------------------------------
module dmem_axil_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,

    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,

    output logic        mem_write,
    output logic [3:0]  byte_en,
    output logic [11:0] write_addr,
    output logic [11:0] read_addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t state;
    grant_t last_grant;

    logic wr_req;
    logic rd_req;
    logic wr_grant;
    logic rd_grant;

    // Second cycle of RD_WAIT: memory output is valid and gets captured.
    logic rd_phase;

    // Range-check result latched at grant, consumed when the response forms.
    logic wr_err;
    logic rd_err;

    logic aw_out_of_range;
    logic ar_out_of_range;

`ifdef DMEM_BRIDGE_ERR_EN
    assign aw_out_of_range = (awaddr[31:10] != BASE_ADDR[31:10]);
    assign ar_out_of_range = (araddr[31:10] != BASE_ADDR[31:10]);
`else
    assign aw_out_of_range = 1'b0;
    assign ar_out_of_range = 1'b0;
`endif

    // Address bits that do not feed the datapath in every build.
    logic unused_bits;
    assign unused_bits = ^{awaddr[31:10], awaddr[1:0], araddr[31:12], BASE_ADDR};

    // Grant decision. Readies are combinational and asserted only in the
    // cycle the grant is taken; held low while reset is asserted.
    always_comb begin
        wr_req   = awvalid && wvalid;
        rd_req   = arvalid;
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (!rst && state == IDLE) begin
            if (wr_req && (!rd_req || last_grant == GRANT_RD)) begin
                wr_grant = 1'b1;
            end else if (rd_req) begin
                rd_grant = 1'b1;
            end
        end
    end

    assign awready = wr_grant;
    assign wready  = wr_grant;
    assign arready = rd_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
            rd_phase   <= 1'b0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            rvalid     <= 1'b0;
            rresp      <= RESP_OKAY;
            rdata      <= '0;
            mem_write  <= 1'b0;
            byte_en    <= '0;
            write_addr <= '0;
            read_addr  <= '0;
            write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_grant) begin
                        write_addr <= {4'b0000, awaddr[9:2]};
                        write_data <= wdata;
                        byte_en    <= wstrb;
                        wr_err     <= aw_out_of_range;
                        mem_write  <= !aw_out_of_range;
                        last_grant <= GRANT_WR;
                        state      <= WR_EXEC;
                    end else if (rd_grant) begin
                        read_addr  <= araddr[11:0];
                        rd_err     <= ar_out_of_range;
                        rd_phase   <= 1'b0;
                        last_grant <= GRANT_RD;
                        state      <= RD_WAIT;
                    end
                end

                WR_EXEC: begin
                    mem_write <= 1'b0;
                    bvalid    <= 1'b1;
                    bresp     <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    state     <= WR_RESP;
                end

                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                // Covers the memory's registered read latency: read_addr is
                // presented in the first cycle, read_data is sampled in the
                // second, so rvalid rises two cycles after the AR handshake.
                RD_WAIT: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        rd_phase <= 1'b0;
                        rdata    <= rd_err ? '0 : read_data;
                        rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid   <= 1'b1;
                        state    <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
